pll_lock_supervisor: RTL and testbench

- Controls and monitors the clock PLL from the reference clock domain.
- Drives the PLL reset, watches its asynchronous locked output, and retries with a timeout when lock is not achieved.
- Releases the design-wide system reset only after lock has been stable for a set time.
- Sits between the board reset and the PLL wrapper; its system reset output feeds the reset synchronisers of the PLL output clock domains.

---
 rtl/pll_pkg.sv | 18 +
 rtl/sync_2ff.sv | 28 ++
 rtl/pll_lock_supervisor.sv | 136 +++++++++++++
 tb/tb_pll_lock_supervisor.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pll_pkg.sv
// Shared definitions for the PLL lock supervisor: FSM state encoding and
// default timing constants (refclk cycles at 50 MHz).
package pll_pkg;

    localparam logic [2:0] S_RESET     = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAIL      = 3'd4;

    localparam int RST_PULSE_CYC_DEF    = 16;
    localparam int LOCK_TIMEOUT_CYC_DEF = 50000;
    localparam int LOCK_STABLE_CYC_DEF  = 1024;
    localparam int MAX_RETRIES_DEF      = 3;
    localparam int CNT_W_DEF            = 16;
    localparam int RETRY_W_DEF          = 2;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchroniser for bringing an asynchronous level
// into the clk domain. Latency is two clk edges.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_p0;
    logic sync_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_p0 <= RST_VAL;
            sync_p1 <= RST_VAL;
        end else begin
            // stage 0: capture (may go metastable); stage 1: resolved copy
            meta_p0 <= d;
            sync_p1 <= meta_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Drives the PLL reset, waits for a stable synchronised lock, retries on
// timeout, and holds the system reset until lock has been stable long enough.
module pll_lock_supervisor
    import pll_pkg::*;
#(
    parameter int RST_PULSE_CYC    = RST_PULSE_CYC_DEF,
    parameter int LOCK_TIMEOUT_CYC = LOCK_TIMEOUT_CYC_DEF,
    parameter int LOCK_STABLE_CYC  = LOCK_STABLE_CYC_DEF,
    parameter int MAX_RETRIES      = MAX_RETRIES_DEF,
    parameter int CNT_W            = CNT_W_DEF,
    parameter int RETRY_W          = RETRY_W_DEF
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked_i,
    output logic               pll_rst_o,
    output logic               sys_rst_o,
    output logic               ready_o,
    output logic               fail_o,
    output logic               lock_lost_o,
    output logic [RETRY_W-1:0] retry_cnt_o
);

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0]   WIN_LAST    = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]   STAB_LAST   = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic             locked_s;
    logic [2:0]       state;
    logic [CNT_W-1:0] rst_cnt;
    logic [CNT_W-1:0] win_cnt;
    logic [CNT_W-1:0] stab_cnt;
    logic             win_expired;
    logic             stab_done;

    sync_2ff #(
        .RST_VAL (1'b0)
    ) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked_i),
        .q   (locked_s)
    );

    assign win_expired = (win_cnt >= WIN_LAST);
    assign stab_done   = (stab_cnt >= STAB_LAST);

    always_ff @(posedge refclk) begin
        if (rst) begin
            state       <= S_RESET;
            rst_cnt     <= '0;
            win_cnt     <= '0;
            stab_cnt    <= '0;
            retry_cnt_o <= '0;
            pll_rst_o   <= 1'b1;
            sys_rst_o   <= 1'b1;
            ready_o     <= 1'b0;
            fail_o      <= 1'b0;
            lock_lost_o <= 1'b0;
        end else begin
            lock_lost_o <= 1'b0;
            case (state)
                S_RESET: begin
                    pll_rst_o <= 1'b1;
                    sys_rst_o <= 1'b1;
                    ready_o   <= 1'b0;
                    if (rst_cnt >= RST_LAST) begin
                        state     <= S_WAIT_LOCK;
                        pll_rst_o <= 1'b0;
                        rst_cnt   <= '0;
                        win_cnt   <= '0;
                    end else begin
                        rst_cnt <= sat_inc(rst_cnt);
                    end
                end
                S_WAIT_LOCK, S_STABLE: begin
                    win_cnt <= sat_inc(win_cnt);
                    // Stable completion takes priority over a coincident window expiry.
                    if (state == S_STABLE && locked_s && stab_done) begin
                        state     <= S_RUN;
                        sys_rst_o <= 1'b0;
                        ready_o   <= 1'b1;
                    end else if (win_expired) begin
                        stab_cnt <= '0;
                        if (retry_cnt_o < RETRY_LIMIT) begin
                            retry_cnt_o <= retry_cnt_o + 1'b1;
                            state       <= S_RESET;
                            pll_rst_o   <= 1'b1;
                            rst_cnt     <= '0;
                        end else begin
                            state     <= S_FAIL;
                            fail_o    <= 1'b1;
                            pll_rst_o <= 1'b0;
                        end
                    end else if (!locked_s) begin
                        state    <= S_WAIT_LOCK;
                        stab_cnt <= '0;
                    end else if (state == S_WAIT_LOCK) begin
                        state    <= S_STABLE;
                        stab_cnt <= '0;
                    end else begin
                        stab_cnt <= sat_inc(stab_cnt);
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        lock_lost_o <= 1'b1;
                        sys_rst_o   <= 1'b1;
                        ready_o     <= 1'b0;
                        retry_cnt_o <= '0;
                        pll_rst_o   <= 1'b1;
                        rst_cnt     <= '0;
                        state       <= S_RESET;
                    end
                end
                S_FAIL: begin
                    pll_rst_o <= 1'b0;
                    sys_rst_o <= 1'b1;
                    ready_o   <= 1'b0;
                    fail_o    <= 1'b1;
                end
                default: begin
                    state     <= S_RESET;
                    pll_rst_o <= 1'b1;
                    rst_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short timing parameters
// (pulse 4, window 100, stable 10, 2 retries).
module tb_pll_lock_supervisor;

    localparam int RETRY_W = 2;

    logic               refclk = 1'b0;
    logic               rst = 1'b1;
    logic               pll_locked_i = 1'b0;
    logic               pll_rst_o;
    logic               sys_rst_o;
    logic               ready_o;
    logic               fail_o;
    logic               lock_lost_o;
    logic [RETRY_W-1:0] retry_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;
    int e        = 0;

    // Locked pattern: high from lock_from, low in [gl_lo, gl_hi], low after drop_after.
    int lock_from  = 1000000;
    int gl_lo      = -1;
    int gl_hi      = -2;
    int drop_after = 1000000;

    pll_lock_supervisor #(
        .RST_PULSE_CYC    (4),
        .LOCK_TIMEOUT_CYC (100),
        .LOCK_STABLE_CYC  (10),
        .MAX_RETRIES      (2),
        .CNT_W            (16),
        .RETRY_W          (RETRY_W)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .pll_locked_i (pll_locked_i),
        .pll_rst_o    (pll_rst_o),
        .sys_rst_o    (sys_rst_o),
        .ready_o      (ready_o),
        .fail_o       (fail_o),
        .lock_lost_o  (lock_lost_o),
        .retry_cnt_o  (retry_cnt_o)
    );

    always #5 refclk = ~refclk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0d expected %0d", tag, e, got, exp);
        end
    endtask

    function automatic logic lock_at(input int k);
        return (k >= lock_from) && !(k >= gl_lo && k <= gl_hi) && !(k > drop_after);
    endfunction

    task automatic step();
        @(posedge refclk);
        #1;
        e++;
    endtask

    task automatic advance_to(input int tgt);
        while (e < tgt) begin
            pll_locked_i = lock_at(e + 1);
            step();
        end
    endtask

    // Edge 0 is the last edge with rst sampled high; rst drops right after it.
    task automatic do_reset();
        rst = 1'b1;
        pll_locked_i = lock_at(0);
        repeat (3) @(posedge refclk);
        #1;
        e = 0;
        rst = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, ".pll_rst"},   pll_rst_o,   1);
        check_eq({tag, ".sys_rst"},   sys_rst_o,   1);
        check_eq({tag, ".ready"},     ready_o,     0);
        check_eq({tag, ".fail"},      fail_o,      0);
        check_eq({tag, ".lock_lost"}, lock_lost_o, 0);
        check_eq({tag, ".retry"},     retry_cnt_o, 0);
    endtask

    initial begin
        // Normal bring-up, then lock loss in RUN
        lock_from = 20; gl_lo = -1; gl_hi = -2; drop_after = 50;
        do_reset();
        check_reset_vals("reset");
        advance_to(3);  check_eq("norm.pll_rst_e3", pll_rst_o, 1);
        advance_to(4);  check_eq("norm.pll_rst_e4", pll_rst_o, 0);
        advance_to(31); check_eq("norm.ready_e31", ready_o, 0);
                        check_eq("norm.sysrst_e31", sys_rst_o, 1);
        advance_to(32); check_eq("norm.ready_e32", ready_o, 1);
                        check_eq("norm.sysrst_e32", sys_rst_o, 0);
                        check_eq("norm.fail", fail_o, 0);
                        check_eq("norm.retry", retry_cnt_o, 0);
        advance_to(52); check_eq("loss.pulse_e52", lock_lost_o, 0);
                        check_eq("loss.ready_e52", ready_o, 1);
        advance_to(53); check_eq("loss.pulse_e53", lock_lost_o, 1);
                        check_eq("loss.sysrst_e53", sys_rst_o, 1);
                        check_eq("loss.ready_e53", ready_o, 0);
                        check_eq("loss.pllrst_e53", pll_rst_o, 1);
        advance_to(54); check_eq("loss.pulse_e54", lock_lost_o, 0);
        advance_to(56); check_eq("loss.pllrst_e56", pll_rst_o, 1);
        advance_to(57); check_eq("loss.pllrst_e57", pll_rst_o, 0);
                        check_eq("loss.retry", retry_cnt_o, 0);

        // Never locks: three attempts then FAIL; rst out of FAIL
        lock_from = 1000000; drop_after = 1000000;
        do_reset();
        advance_to(103); check_eq("nolock.retry_e103", retry_cnt_o, 0);
        advance_to(104); check_eq("nolock.retry_e104", retry_cnt_o, 1);
                         check_eq("nolock.pllrst_e104", pll_rst_o, 1);
        advance_to(108); check_eq("nolock.pllrst_e108", pll_rst_o, 0);
        advance_to(208); check_eq("nolock.retry_e208", retry_cnt_o, 2);
                         check_eq("nolock.pllrst_e208", pll_rst_o, 1);
        advance_to(311); check_eq("nolock.fail_e311", fail_o, 0);
        advance_to(312); check_eq("nolock.fail_e312", fail_o, 1);
                         check_eq("nolock.pllrst_e312", pll_rst_o, 0);
                         check_eq("nolock.sysrst_e312", sys_rst_o, 1);
        advance_to(330); check_eq("nolock.fail_e330", fail_o, 1);
                         check_eq("nolock.pllrst_e330", pll_rst_o, 0);
                         check_eq("nolock.ready_e330", ready_o, 0);
        rst = 1'b1;
        step();
        check_reset_vals("rst_in_fail");

        // rst in WAIT_LOCK with one retry used
        do_reset();
        advance_to(150); check_eq("midrst.retry_pre", retry_cnt_o, 1);
                         check_eq("midrst.pllrst_pre", pll_rst_o, 0);
        rst = 1'b1;
        step();
        check_reset_vals("rst_in_wait");
        rst = 1'b0;

        // Glitch in STABLE after 5 stable cycles
        lock_from = 20; gl_lo = 28; gl_hi = 30; drop_after = 1000000;
        do_reset();
        advance_to(32); check_eq("glitch.ready_e32", ready_o, 0);
        advance_to(42); check_eq("glitch.ready_e42", ready_o, 0);
        advance_to(43); check_eq("glitch.ready_e43", ready_o, 1);
                        check_eq("glitch.retry", retry_cnt_o, 0);

        // Stale locked held through S_RESET; WAIT_LOCK entered at edge 4
        lock_from = -1000; gl_lo = -1; gl_hi = -2;
        do_reset();
        advance_to(14); check_eq("stale.ready_e14", ready_o, 0);
        advance_to(15); check_eq("stale.ready_e15", ready_o, 1);

        // Stable completion coincides with window expiry at edge 104
        lock_from = 92;
        do_reset();
        advance_to(103); check_eq("coinc.ready_e103", ready_o, 0);
        advance_to(104); check_eq("coinc.ready_e104", ready_o, 1);
                         check_eq("coinc.retry", retry_cnt_o, 0);
                         check_eq("coinc.pllrst", pll_rst_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
